lsu_mem: RTL and testbench

LSU_MEM -- requirements
Module: lsu_mem

---
 rtl/lsu_mem.sv | 119 +++++++++++
 tb/tb_lsu_mem.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem.sv
// Load/store unit with a private single-port word RAM: byte/half/word accesses,
// little-endian lanes, alignment checking and one outstanding request at a time.
module lsu_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] RD2,
  output logic [31:0] ReadData,
  output logic        rd_valid,
  output logic        st_done,
  output logic        misaligned,
  output logic        Stall
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, ERR} state_t;

  state_t                  state;
  logic [2:0]              f3_q;
  logic [ADDR_WIDTH+1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic                    req_bad;
  logic [3:0]              be;
  logic [31:0]             wlane;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [31:0]             fmt;
  logic [ADDR_WIDTH-1:0]   widx;
  logic                    unused_addr;
  logic [31:0]             mem [2**ADDR_WIDTH];

  // Address bits above the RAM size are deliberately dropped so accesses wrap.
  assign unused_addr = ^ALUResult[31:ADDR_WIDTH+2];
  assign widx        = addr_q[ADDR_WIDTH+1:2];

  always_comb begin
    req_bad = 1'b0;
    case (funct3)
      3'b000:         req_bad = 1'b0;
      3'b001:         req_bad = ALUResult[0];
      3'b010:         req_bad = |ALUResult[1:0];
      3'b100, 3'b101: req_bad = MemWrite | (funct3[0] & ALUResult[0]);
      default:        req_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q    <= funct3;
            addr_q  <= ALUResult[ADDR_WIDTH+1:0];
            wdata_q <= RD2;
            if (req_bad)       state <= ERR;
            else if (MemWrite) state <= WRITE;
            else               state <= READ;
          end
        end
        READ:    state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // A reset arriving while in WRITE cancels the store, so the write is gated by rst.
  always_ff @(posedge clk) begin
    if (state == WRITE && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[widx][8*k +: 8] <= wlane[8*k +: 8];
      end
    end
    if (state == READ) rdata_q <= mem[widx];
  end

  always_comb begin
    byte_sel = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  fmt = {24'b0, byte_sel};
      3'b001:  fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  fmt = {16'b0, half_sel};
      default: fmt = rdata_q;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign Stall      = ~req_ready;
  assign st_done    = (state == WRITE) && !rst;
  assign rd_valid   = (state == RESP) && !rst;
  assign misaligned = (state == ERR) && !rst;
  assign ReadData   = rd_valid ? fmt : 32'b0;

endmodule

// File: tb/tb_lsu_mem.sv
// Randomized scoreboard bench for lsu_mem against a byte-array memory model.
module tb_lsu_mem;
  localparam int AW        = 10;
  localparam int MEM_BYTES = 4 << AW;
  localparam int K_LOAD    = 0;
  localparam int K_STORE   = 1;
  localparam int K_MIS     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] ALUResult = 32'b0;
  logic [31:0] RD2 = 32'b0;
  logic        req_ready;
  logic [31:0] ReadData;
  logic        rd_valid;
  logic        st_done;
  logic        misaligned;
  logic        Stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] model_mem [MEM_BYTES];

  lsu_mem #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .MemWrite(MemWrite), .funct3(funct3), .ALUResult(ALUResult), .RD2(RD2),
    .ReadData(ReadData), .rd_valid(rd_valid), .st_done(st_done),
    .misaligned(misaligned), .Stall(Stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference behaviour: memory is a flat array of bytes, accesses are runs of 1/2/4 bytes.
  task automatic modelIssue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, output int kind, output logic [31:0] val);
    int nbytes;
    bit legal;
    logic [31:0] v;
    nbytes = 1 << (f3 % 4);
    legal  = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    val    = 32'b0;
    if (!legal || (addr % nbytes) != 0) begin
      kind = K_MIS;
      return;
    end
    if (we) begin
      kind = K_STORE;
      for (int i = 0; i < nbytes; i++) model_mem[(addr + i) % MEM_BYTES] = data[8*i +: 8];
    end else begin
      kind = K_LOAD;
      v = 32'b0;
      for (int i = 0; i < nbytes; i++) v[8*i +: 8] = model_mem[(addr + i) % MEM_BYTES];
      if (f3 < 4 && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'd1 << (8*nbytes)) - 1);
      val = v;
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] data, input bit track, output int acc);
    int waited;
    int kind;
    logic [31:0] val;
    exp_t e;
    @(negedge clk);
    MemWrite  = we;
    funct3    = f3;
    ALUResult = addr;
    RD2       = data;
    req_valid = 1'b1;
    waited    = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout actual=req_ready 0 expected=req_ready 1");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (track) begin
      modelIssue(we, f3, addr, data, kind, val);
      e.kind = kind;
      e.data = val;
      e.cyc  = acc + ((kind == K_LOAD) ? 2 : 1);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Monitor: interface invariants every cycle plus in-order response matching.
  int   mon_np;
  int   mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("stall is not ready", Stall, !req_ready);
      if (!rd_valid) checkOutput("readdata idle zero", ReadData, 32'b0);
      mon_np = rd_valid + st_done + misaligned;
      checkOutput("pulses exclusive", mon_np <= 1, 1);
      if (mon_np != 0) begin
        mon_kind = rd_valid ? K_LOAD : (st_done ? K_STORE : K_MIS);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected response actual=kind %0d expected=none (cycle %0d)", mon_kind, cyc);
        end else begin
          mon_e = sbq.pop_front();
          checkOutput("response kind", mon_kind, mon_e.kind);
          checkOutput("response cycle", cyc, mon_e.cyc);
          if (mon_kind == K_LOAD && mon_e.kind == K_LOAD) checkOutput("load data", ReadData, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, acc2, gap, w;
    int idx, low;
    logic [31:0] addr;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset req_ready", req_ready, 1);
    checkOutput("reset stall", Stall, 0);
    checkOutput("reset rd_valid", rd_valid, 0);
    checkOutput("reset st_done", st_done, 0);
    checkOutput("reset misaligned", misaligned, 0);
    checkOutput("reset readdata", ReadData, 0);

    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 3'b010, 32'(i * 4), $urandom(), 1, acc);

    $display("[TB] directed store/load and sub-word accesses");
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, acc);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1, acc2);
    checkOutput("store to load accept gap", acc2 - acc, 2);
    applyStimulus(1'b1, 3'b000, 32'h13, 32'h80, 1, acc);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 1, acc);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 1, acc);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1, acc);
    applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 1, acc);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 1, acc);
    applyStimulus(1'b1, 3'b001, 32'h16, 32'h0000_8001, 1, acc);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 1, acc);

    $display("[TB] misaligned and illegal requests");
    applyStimulus(1'b0, 3'b001, 32'h11, 32'h0, 1, acc);
    applyStimulus(1'b1, 3'b010, 32'h12, 32'h1111_1111, 1, acc);
    applyStimulus(1'b1, 3'b100, 32'h10, 32'h2222_2222, 1, acc);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, 1, acc);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1, acc);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 3'b010, 32'h1000, 32'h12345678, 1, acc);
    applyStimulus(1'b0, 3'b010, 32'h0, 32'h0, 1, acc);

    $display("[TB] reset aborts a store");
    applyStimulus(1'b1, 3'b010, 32'h20, 32'hFFFF_FFFF, 0, acc);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("st_done aborted", st_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle after store abort", req_ready, 1);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1, acc);

    $display("[TB] reset aborts a load");
    applyStimulus(1'b0, 3'b010, 32'h24, 32'h0, 0, acc);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle after load abort", req_ready, 1);
    checkOutput("no rd_valid after load abort", rd_valid, 0);

    $display("[TB] reset wins over a request");
    @(negedge clk);
    MemWrite = 1'b1; funct3 = 3'b010; ALUResult = 32'h30; RD2 = 32'hA5A5_A5A5;
    req_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 begin rst = 1'b0; req_valid = 1'b0; end
    @(negedge clk);
    checkOutput("idle after reset with request", req_ready, 1);
    applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, 1, acc);

    $display("[TB] back-to-back loads");
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1, acc);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 1, acc2);
    checkOutput("second load accept gap", acc2 - acc, 3);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      idx  = $urandom_range(0, 63);
      low  = $urandom_range(0, 3);
      addr = ($urandom() & 32'hFFFF_F000) | 32'(idx << 2) | 32'(low);
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom(), 1, acc);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    w = 0;
    while (sbq.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("scoreboard drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
